regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for three register-file write requesters.
// It issues registered grants and drives the register-file write port.
module regfile_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [NUM_REQ-1:0]    i_Req,
    input  logic [ADDR_WIDTH-1:0] i_Addr0,
    input  logic [ADDR_WIDTH-1:0] i_Addr1,
    input  logic [ADDR_WIDTH-1:0] i_Addr2,
    output logic [NUM_REQ-1:0]    o_Gnt,
    output logic                  o_WE,
    output logic [1:0]            o_WDSrc,
    output logic [ADDR_WIDTH-1:0] o_WAddr,
    output logic                  o_Busy
);

    // Handshake: i_Req[k] is the valid and o_Gnt[k] the ready/ack. A requester
    // holds i_Req[k], address and data until the end of the cycle in which
    // o_Gnt[k] is high; that cycle completes the transfer. Withdrawing before
    // a grant is legal and simply yields no grant.

    logic [NUM_REQ-1:0]    r_Gnt;
    logic                  r_WE;
    logic [1:0]            r_WDSrc;
    logic [ADDR_WIDTH-1:0] r_WAddr;
    logic [1:0]            r_Ptr;

    logic [NUM_REQ-1:0]    w_ReqEff;
    logic [1:0]            w_Order [3];
    logic [1:0]            w_Sel;
    logic                  w_Found;
    logic [ADDR_WIDTH-1:0] w_SelAddr;

    // The requester granted last cycle is masked so nobody wins twice in a row.
    assign w_ReqEff = i_Req & ~r_Gnt;

    always_comb begin
        w_Order[0] = 2'd0;
        w_Order[1] = 2'd1;
        w_Order[2] = 2'd2;
        case (r_Ptr)
            2'd1: begin
                w_Order[0] = 2'd1;
                w_Order[1] = 2'd2;
                w_Order[2] = 2'd0;
            end
            2'd2: begin
                w_Order[0] = 2'd2;
                w_Order[1] = 2'd0;
                w_Order[2] = 2'd1;
            end
            default: begin
                w_Order[0] = 2'd0;
                w_Order[1] = 2'd1;
                w_Order[2] = 2'd2;
            end
        endcase
    end

    // Scan from lowest priority to highest so the last match wins.
    always_comb begin
        w_Sel   = 2'd0;
        w_Found = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (w_ReqEff[w_Order[i]]) begin
                w_Sel   = w_Order[i];
                w_Found = 1'b1;
            end
        end
    end

    always_comb begin
        w_SelAddr = i_Addr0;
        case (w_Sel)
            2'd1:    w_SelAddr = i_Addr1;
            2'd2:    w_SelAddr = i_Addr2;
            default: w_SelAddr = i_Addr0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Gnt   <= '0;
            r_WE    <= 1'b0;
            r_WDSrc <= 2'd0;
            r_WAddr <= '0;
            r_Ptr   <= 2'd0;
        end else if (w_Found) begin
            r_Gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_Sel;
            // Register 0 is hard-wired; the request is consumed without a write.
            r_WE    <= (w_SelAddr != '0);
            r_WDSrc <= w_Sel;
            r_WAddr <= w_SelAddr;
            r_Ptr   <= (w_Sel == 2'd2) ? 2'd0 : w_Sel + 2'd1;
        end else begin
            r_Gnt <= '0;
            r_WE  <= 1'b0;
        end
    end

    assign o_Gnt   = r_Gnt;
    assign o_WE    = r_WE;
    assign o_WDSrc = r_WDSrc;
    assign o_WAddr = r_WAddr;
    assign o_Busy  = (|i_Req) | (|r_Gnt);

endmodule
